// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared constants for the alarm ring controller: state encoding, counter width and
// BCD digit widths used by the clock/alarm counters.
package alarm_ring_ctrl_pkg;

  localparam int unsigned ALM_CW = 9;

  localparam int unsigned H10_W = 2;
  localparam int unsigned H1_W  = 4;
  localparam int unsigned M10_W = 3;
  localparam int unsigned M1_W  = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRing   = 2'b01,
    StSnooze = 2'b10
  } alm_state_e;

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable down-counter of 1 Hz ticks; DONE pulses on the tick that takes it from 1 to 0.
// LOAD has priority over TICK, so a tick arriving with a load is consumed by the load.
module alarm_sec_timer
  import alarm_ring_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOAD,
  input  logic [ALM_CW-1:0] LOAD_VAL,
  input  logic              TICK,
  output logic              DONE
);

  logic [ALM_CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = LOAD_VAL;
    end else if (TICK && (cnt_q != '0)) begin
      cnt_d = cnt_q - ALM_CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Not gated by LOAD: the controller's own load decision depends on DONE.
  assign DONE = TICK & (cnt_q == ALM_CW'(1));

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: detects entry into the alarm minute and sequences ring/stop/snooze.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK_1HZ,
  input  logic             ALARM_EN,
  input  logic             STOP_BTN,
  input  logic             SNOOZE_BTN,
  input  logic [H10_W-1:0] ALM_H10,
  input  logic [H1_W-1:0]  ALM_H1,
  input  logic [M10_W-1:0] ALM_M10,
  input  logic [M1_W-1:0]  ALM_M1,
  input  logic [H10_W-1:0] CUR_H10,
  input  logic [H1_W-1:0]  CUR_H1,
  input  logic [M10_W-1:0] CUR_M10,
  input  logic [M1_W-1:0]  CUR_M1,
  output logic             BUZZER,
  output logic             ALARM_LED,
  output logic             RINGING
);

  localparam logic [ALM_CW-1:0] RingLd = ALM_CW'(RING_SEC);

  alm_state_e        state_q, state_d;
  logic              buzzer_q, buzzer_d;
  logic              led_q, ringing_q;
  logic              match, match_q, hit;
  logic              load;
  logic [ALM_CW-1:0] load_val;
  logic              done;

  assign match = (ALM_H10 == CUR_H10) && (ALM_H1 == CUR_H1) &&
                 (ALM_M10 == CUR_M10) && (ALM_M1 == CUR_M1);
  assign hit   = match & ~match_q;

`ifdef ALARM_SNOOZE_EN
  localparam logic [ALM_CW-1:0] SnoozeLd = ALM_CW'(SNOOZE_SEC);
`else
  logic unused_snooze;
  assign unused_snooze = SNOOZE_BTN ^ (SNOOZE_SEC == 0);
`endif

  alarm_sec_timer u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .TICK     (TICK_1HZ),
    .DONE     (done)
  );

  always_comb begin
    state_d  = state_q;
    buzzer_d = buzzer_q;
    load     = 1'b0;
    load_val = '0;
    if (!ALARM_EN) begin
      state_d  = StIdle;
      buzzer_d = 1'b0;
      load     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          buzzer_d = 1'b0;
          if (hit) begin
            state_d  = StRing;
            buzzer_d = 1'b1;
            load     = 1'b1;
            load_val = RingLd;
          end
        end
        StRing: begin
          if (STOP_BTN) begin
            state_d  = StIdle;
            buzzer_d = 1'b0;
            load     = 1'b1;
`ifdef ALARM_SNOOZE_EN
          end else if (SNOOZE_BTN) begin
            state_d  = StSnooze;
            buzzer_d = 1'b0;
            load     = 1'b1;
            load_val = SnoozeLd;
`endif
          end else if (done) begin
            state_d  = StIdle;
            buzzer_d = 1'b0;
          end else if (TICK_1HZ) begin
            buzzer_d = ~buzzer_q;
          end
        end
`ifdef ALARM_SNOOZE_EN
        StSnooze: begin
          buzzer_d = 1'b0;
          if (STOP_BTN) begin
            state_d = StIdle;
            load    = 1'b1;
          end else if (done) begin
            state_d  = StRing;
            buzzer_d = 1'b1;
            load     = 1'b1;
            load_val = RingLd;
          end
        end
`endif
        default: begin
          state_d  = StIdle;
          buzzer_d = 1'b0;
          load     = 1'b1;
        end
      endcase
    end
  end

  // match_q resets high so a 00:00 == 00:00 match straight out of reset is not a hit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      buzzer_q  <= 1'b0;
      led_q     <= 1'b0;
      ringing_q <= 1'b0;
      match_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      buzzer_q  <= buzzer_d;
      led_q     <= (state_d != StIdle);
      ringing_q <= (state_d == StRing);
      match_q   <= match;
    end
  end

  assign BUZZER    = buzzer_q;
  assign ALARM_LED = led_q;
  assign RINGING   = ringing_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed scenarios plus randomized traffic against a
// mode/seconds-remaining reference model. Honours ALARM_SNOOZE_EN like the design.
module tb_alarm_ring_ctrl;

  localparam int RingSec   = 60;
  localparam int SnoozeSec = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SnzBuild = 1'b1;
`else
  localparam bit SnzBuild = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, tick, en, stop, snz;
  logic [1:0] ah10, ch10;
  logic [3:0] ah1, am1, ch1, cm1;
  logic [2:0] am10, cm10;
  logic       buzzer, led, ringing;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 idle, 1 ring, 2 snooze; seconds left; ticks elapsed in ring.
  int m_mode, m_left, m_elapsed;
  bit m_prev;

  always #5 clk = ~clk;

  alarm_ring_ctrl #(
    .RING_SEC   (RingSec),
    .SNOOZE_SEC (SnoozeSec)
  ) dut (
    .CLK        (clk),
    .RESET      (reset),
    .TICK_1HZ   (tick),
    .ALARM_EN   (en),
    .STOP_BTN   (stop),
    .SNOOZE_BTN (snz),
    .ALM_H10    (ah10),
    .ALM_H1     (ah1),
    .ALM_M10    (am10),
    .ALM_M1     (am1),
    .CUR_H10    (ch10),
    .CUR_H1     (ch1),
    .CUR_M10    (cm10),
    .CUR_M1     (cm1),
    .BUZZER     (buzzer),
    .ALARM_LED  (led),
    .RINGING    (ringing)
  );

  task automatic model_step();
    bit m_match, m_hit;
    m_match = ({ah10, ah1, am10, am1} == {ch10, ch1, cm10, cm1});
    m_hit   = m_match && !m_prev;
    if (reset) begin
      m_mode = 0; m_left = 0; m_elapsed = 0; m_prev = 1'b1;
      return;
    end
    m_prev = m_match;
    if (!en) begin
      m_mode = 0; m_left = 0;
    end else if (m_mode == 0) begin
      if (m_hit) begin m_mode = 1; m_left = RingSec; m_elapsed = 0; end
    end else if (m_mode == 1) begin
      if (stop) m_mode = 0;
      else if (SnzBuild && snz) begin m_mode = 2; m_left = SnoozeSec; end
      else if (tick) begin
        m_left--; m_elapsed++;
        if (m_left == 0) m_mode = 0;
      end
    end else begin
      if (stop) m_mode = 0;
      else if (tick) begin
        m_left--;
        if (m_left == 0) begin m_mode = 1; m_left = RingSec; m_elapsed = 0; end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input int h, input int m);
    ch10 = 2'(h / 10); ch1 = 4'(h % 10); cm10 = 3'(m / 10); cm1 = 4'(m % 10);
  endtask

  task automatic set_alm(input int h, input int m);
    ah10 = 2'(h / 10); ah1 = 4'(h % 10); am10 = 3'(m / 10); am1 = 4'(m % 10);
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cycle(); tick = 1'b0; cycle();
  endtask

  // Brings an idle controller into RING with alarm at 07:30.
  task automatic start_ring();
    set_cur(7, 29); cycle();
    set_cur(7, 30); cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; tick = 0; stop = 0; snz = 0;
    set_alm(0, 0); set_cur(0, 0);
    cycle(); cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if ({ringing, led, buzzer} !== 3'b000) begin
        n_errors++; $display("FAIL reset_no_ring: got %b want 000", {ringing, led, buzzer});
      end
    end
  endtask

  task automatic test_ring_expiry();
    logic exp_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    set_alm(7, 30);
    start_ring();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b111) begin
      n_errors++; $display("FAIL ring_start: got %b want 111", {ringing, led, buzzer});
    end
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1; cycle(); tick = 1'b0;
      n_checks++;
      if (buzzer !== exp_b[i]) begin
        n_errors++; $display("FAIL buzzer_pattern[%0d]: got %b want %b", i, buzzer, exp_b[i]);
      end
      cycle();
    end
    for (int i = 0; i < RingSec - 5; i++) pulse_tick();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b110) begin
      n_errors++; $display("FAIL ring_before_expiry: got %b want 110", {ringing, led, buzzer});
    end
    tick = 1'b1; cycle(); tick = 1'b0;
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL ring_expiry: got %b want 000", {ringing, led, buzzer});
    end
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL held_match_no_retrigger: got %b want 000", {ringing, led, buzzer});
    end
  endtask

  task automatic test_stop_snooze_same();
    start_ring();
    stop = 1'b1; snz = 1'b1; cycle(); stop = 1'b0; snz = 1'b0;
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL stop_and_snooze: got %b want 000", {ringing, led, buzzer});
    end
    stop = 1'b1; snz = 1'b1; tick = 1'b1; cycle(); stop = 1'b0; snz = 1'b0; tick = 1'b0;
    cycle(); cycle();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL idle_buttons_ignored: got %b want 000", {ringing, led, buzzer});
    end
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    start_ring();
    snz = 1'b1; cycle(); snz = 1'b0;
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b010) begin
      n_errors++; $display("FAIL snooze_enter: got %b want 010", {ringing, led, buzzer});
    end
    snz = 1'b1; cycle(); snz = 1'b0;
    pulse_tick(); pulse_tick();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b010) begin
      n_errors++; $display("FAIL snooze_hold: got %b want 010", {ringing, led, buzzer});
    end
    tick = 1'b1; cycle(); tick = 1'b0;
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b111) begin
      n_errors++; $display("FAIL snooze_rering: got %b want 111", {ringing, led, buzzer});
    end
    stop = 1'b1; cycle(); stop = 1'b0;
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL snooze_then_stop: got %b want 000", {ringing, led, buzzer});
    end
  endtask
`else
  task automatic test_no_snooze();
    start_ring();
    pulse_tick();
    snz = 1'b1; cycle(); snz = 1'b0;
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b110) begin
      n_errors++; $display("FAIL snooze_ignored: got %b want 110", {ringing, led, buzzer});
    end
    for (int i = 0; i < RingSec - 2; i++) pulse_tick();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b110) begin
      n_errors++; $display("FAIL counter_continues: got %b want 110", {ringing, led, buzzer});
    end
    tick = 1'b1; cycle(); tick = 1'b0;
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL expiry_after_snooze_press: got %b want 000", {ringing, led, buzzer});
    end
  endtask
`endif

  task automatic test_alarm_en();
    start_ring();
    en = 1'b0; cycle();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL en_drop: got %b want 000", {ringing, led, buzzer});
    end
    en = 1'b1; cycle(); cycle(); cycle();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL en_raise_held_match: got %b want 000", {ringing, led, buzzer});
    end
    set_cur(7, 31); cycle();
    set_cur(7, 30); cycle();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b111) begin
      n_errors++; $display("FAIL reenter_minute: got %b want 111", {ringing, led, buzzer});
    end
    stop = 1'b1; cycle(); stop = 1'b0;
    set_alm(8, 0); cycle();
    set_alm(7, 30); cycle();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b111) begin
      n_errors++; $display("FAIL edit_creates_match: got %b want 111", {ringing, led, buzzer});
    end
    reset = 1'b1; cycle(); reset = 1'b0;
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL reset_mid_ring: got %b want 000", {ringing, led, buzzer});
    end
    cycle(); cycle();
    n_checks++;
    if ({ringing, led, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL post_reset_held_match: got %b want 000", {ringing, led, buzzer});
    end
  endtask

  task automatic test_random();
    logic exp_b, exp_l, exp_r;
    for (int i = 0; i < 4000; i++) begin
      tick  = ($urandom_range(2) == 0);
      stop  = ($urandom_range(59) == 0);
      snz   = ($urandom_range(29) == 0);
      en    = ($urandom_range(149) != 0);
      reset = ($urandom_range(799) == 0);
      if ($urandom_range(24) == 0) begin
        if ($urandom_range(1) == 0) set_cur(7, 30);
        else set_cur(7, 29 + 2 * $urandom_range(1));
      end
      if ($urandom_range(199) == 0) begin
        if ($urandom_range(1) == 0) set_alm(7, 30);
        else begin ah10 = ch10; ah1 = ch1; am10 = cm10; am1 = cm1; end
      end
      cycle();
      exp_r = (m_mode == 1);
      exp_l = (m_mode != 0);
      exp_b = (m_mode == 1) && (m_elapsed % 2 == 0);
      n_checks++;
      if ({ringing, led, buzzer} !== {exp_r, exp_l, exp_b}) begin
        n_errors++;
        $display("FAIL random[%0d]: got %b want %b", i, {ringing, led, buzzer},
                 {exp_r, exp_l, exp_b});
      end
    end
    reset = 1'b0; tick = 1'b0; stop = 1'b0; snz = 1'b0; en = 1'b1;
  endtask

  initial begin
    m_mode = 0; m_left = 0; m_elapsed = 0; m_prev = 1'b1;
    test_reset();
    test_ring_expiry();
    test_stop_snooze_same();
`ifdef ALARM_SNOOZE_EN
    test_snooze();
`else
    test_no_snooze();
`endif
    test_alarm_en();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
